// File: rtl/multicycle_controller.sv
// Multi-cycle minisys-32 control unit: decodes op/func and sequences FETCH/DECODE/EXEC/MEM/WB.
// Latency: j/jr/branch 3, R/I/jal/sw 4, lw 5 cycles; each mem_ready-low cycle adds 1.
// Backpressure: stalls in FETCH/MEM until mem_ready; watchdog halts with bus_err after MEM_TIMEOUT waits.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int RETIRE_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         inst,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                alu_src,
    output logic                sftmd,
    output logic                i_format,
    output logic                jr,
    output logic                jmp,
    output logic                jal,
    output logic                branch,
    output logic                nbranch,
    output logic [1:0]          alu_op,
    output logic [2:0]          state,
    output logic                bus_err,
    output logic                halted,
    output logic [RETIRE_W-1:0] retired
);

    localparam int WD_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MEM_TIMEOUT);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    state_t              st;
    logic [WD_W-1:0]     wd_cnt;
    logic                bus_err_q;
    logic [RETIRE_W-1:0] retired_q;

    logic dec_rtype, dec_jr, dec_sftmd, dec_ifmt, dec_lw, dec_sw;
    logic dec_beq, dec_bne, dec_j, dec_jal;

    logic [5:0] op;
    logic [5:0] func;
    logic       is_rtype, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_ifmt, is_legal;
    logic       unused_inst;

    assign op          = inst[31:26];
    assign func        = inst[5:0];
    assign unused_inst = ^inst[25:6];

    assign is_rtype = (op == 6'b000000);
    assign is_lw    = (op == 6'b100011);
    assign is_sw    = (op == 6'b101011);
    assign is_beq   = (op == 6'b000100);
    assign is_bne   = (op == 6'b000101);
    assign is_j     = (op == 6'b000010);
    assign is_jal   = (op == 6'b000011);
    assign is_ifmt  = (op[5:3] == 3'b001);
    assign is_legal = is_rtype | is_lw | is_sw | is_beq | is_bne | is_j | is_jal | is_ifmt;

    logic       wait_st;
    logic       wd_expire;
    logic       retire;
    logic [1:0] pc_sel;

    assign wait_st   = (st == S_FETCH) || (st == S_MEM);
    assign wd_expire = (MEM_TIMEOUT != 0) && wait_st && !mem_ready && (wd_cnt == WD_LIMIT);

    always_comb begin
        retire = 1'b0;
        pc_sel = 2'b00;
        case (st)
            S_EXEC: begin
                if (dec_j) begin
                    retire = 1'b1;
                    pc_sel = 2'b10;
                end else if (dec_jr) begin
                    retire = 1'b1;
                    pc_sel = 2'b11;
                end else if (dec_beq) begin
                    retire = 1'b1;
                    pc_sel = zero ? 2'b01 : 2'b00;
                end else if (dec_bne) begin
                    retire = 1'b1;
                    pc_sel = zero ? 2'b00 : 2'b01;
                end
            end
            S_MEM: retire = mem_ready && dec_sw;
            S_WB: begin
                retire = 1'b1;
                if (dec_jal) pc_sel = 2'b10;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= S_FETCH;
            wd_cnt    <= '0;
            bus_err_q <= 1'b0;
            retired_q <= '0;
            dec_rtype <= 1'b0;
            dec_jr    <= 1'b0;
            dec_sftmd <= 1'b0;
            dec_ifmt  <= 1'b0;
            dec_lw    <= 1'b0;
            dec_sw    <= 1'b0;
            dec_beq   <= 1'b0;
            dec_bne   <= 1'b0;
            dec_j     <= 1'b0;
            dec_jal   <= 1'b0;
        end else begin
            case (st)
                S_FETCH: begin
                    if (mem_ready)      st <= S_DECODE;
                    else if (wd_expire) st <= S_HALT;
                end
                S_DECODE: begin
                    st        <= is_legal ? S_EXEC : S_HALT;
                    dec_rtype <= is_rtype;
                    dec_jr    <= is_rtype && (func == 6'b001000);
                    dec_sftmd <= is_rtype && (func[5:3] == 3'b000);
                    dec_ifmt  <= is_ifmt;
                    dec_lw    <= is_lw;
                    dec_sw    <= is_sw;
                    dec_beq   <= is_beq;
                    dec_bne   <= is_bne;
                    dec_j     <= is_j;
                    dec_jal   <= is_jal;
                end
                S_EXEC: begin
                    if (retire)                 st <= S_FETCH;
                    else if (dec_lw || dec_sw)  st <= S_MEM;
                    else                        st <= S_WB;
                end
                S_MEM: begin
                    if (retire)         st <= S_FETCH;
                    else if (mem_ready) st <= S_WB;
                    else if (wd_expire) st <= S_HALT;
                end
                S_WB:    st <= S_FETCH;
                S_HALT:  st <= S_HALT;
                default: st <= S_HALT;
            endcase

            // Counts consecutive stall cycles; any non-waiting cycle or handshake rearms it.
            if (wait_st && !mem_ready && (MEM_TIMEOUT != 0)) wd_cnt <= wd_cnt + WD_W'(1);
            else                                           wd_cnt <= '0;

            if (wd_expire) bus_err_q <= 1'b1;
            if (retire)    retired_q <= retired_q + RETIRE_W'(1);
        end
    end

    logic dec_act;
    assign dec_act = !rst && ((st == S_EXEC) || (st == S_MEM) || (st == S_WB));

    assign mem_req    = !rst && wait_st;
    assign mem_we     = !rst && (st == S_MEM) && dec_sw;
    assign ir_write   = !rst && (st == S_FETCH) && mem_ready;
    assign pc_write   = !rst && retire;
    assign pc_src     = rst ? 2'b00 : pc_sel;
    assign reg_write  = !rst && (st == S_WB);
    assign reg_dst    = dec_act && dec_rtype;
    assign mem_to_reg = dec_act && dec_lw;
    assign alu_src    = dec_act && (dec_ifmt || dec_lw || dec_sw);
    assign sftmd      = dec_act && dec_sftmd;
    assign i_format   = dec_act && dec_ifmt;
    assign jr         = dec_act && dec_jr;
    assign jmp        = dec_act && dec_j;
    assign jal        = dec_act && dec_jal;
    assign branch     = dec_act && dec_beq;
    assign nbranch    = dec_act && dec_bne;
    assign alu_op     = dec_act ? {dec_rtype || dec_ifmt, dec_beq || dec_bne} : 2'b00;
    assign state      = rst ? 3'd0 : st;
    assign bus_err    = !rst && bus_err_q;
    assign halted     = !rst && (st == S_HALT);
    assign retired    = rst ? '0 : retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed and randomized bench for multicycle_controller with a per-instruction cycle model.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst = 32'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;

    logic        mem_req, mem_we, ir_write, pc_write, reg_write;
    logic [1:0]  pc_src;
    logic        reg_dst, mem_to_reg, alu_src, sftmd, i_format, jr, jmp, jal, branch, nbranch;
    logic [1:0]  alu_op;
    logic [2:0]  state;
    logic        bus_err, halted;
    logic [31:0] retired;

    multicycle_controller #(.MEM_TIMEOUT(4), .RETIRE_W(32)) dut (
        .clk(clk), .rst(rst), .inst(inst), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src(alu_src), .sftmd(sftmd), .i_format(i_format), .jr(jr), .jmp(jmp),
        .jal(jal), .branch(branch), .nbranch(nbranch), .alu_op(alu_op), .state(state),
        .bus_err(bus_err), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int unsigned model_retired = 0;

    logic [11:0] dec_obs;
    logic [6:0]  hs_obs;
    assign dec_obs = {reg_dst, alu_src, sftmd, i_format, jr, jmp, jal, branch, nbranch, mem_to_reg, alu_op};
    assign hs_obs  = {mem_req, mem_we, ir_write, pc_write, reg_write, pc_src};

    typedef enum int {K_R, K_JR, K_I, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_ILL} kind_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic kind_t classify(input logic [31:0] w);
        logic [5:0] op;
        op = w[31:26];
        if (op == 6'd0)              return (w[5:0] == 6'h08) ? K_JR : K_R;
        if (op == 6'h23)             return K_LW;
        if (op == 6'h2B)             return K_SW;
        if (op == 6'h04)             return K_BEQ;
        if (op == 6'h05)             return K_BNE;
        if (op == 6'h02)             return K_J;
        if (op == 6'h03)             return K_JAL;
        if (op >= 6'd8 && op < 6'd16) return K_I;
        return K_ILL;
    endfunction

    // {reg_dst, alu_src, sftmd, i_format, jr, jmp, jal, branch, nbranch, mem_to_reg, alu_op}
    function automatic logic [11:0] exp_dec(input kind_t k, input logic [31:0] w);
        logic rd, as, sf, ifm, jrr, jm, jl, br, nbr, m2r;
        logic [1:0] ao;
        {rd, as, sf, ifm, jrr, jm, jl, br, nbr, m2r} = 10'd0;
        ao = 2'b00;
        case (k)
            K_R:   begin rd = 1'b1; sf = (w[5:3] == 3'b000); ao = 2'b10; end
            K_JR:  begin rd = 1'b1; jrr = 1'b1; ao = 2'b10; end
            K_I:   begin as = 1'b1; ifm = 1'b1; ao = 2'b10; end
            K_LW:  begin as = 1'b1; m2r = 1'b1; end
            K_SW:  as = 1'b1;
            K_BEQ: begin br = 1'b1; ao = 2'b01; end
            K_BNE: begin nbr = 1'b1; ao = 2'b01; end
            K_J:   jm = 1'b1;
            K_JAL: jl = 1'b1;
            default: ;
        endcase
        return {rd, as, sf, ifm, jrr, jm, jl, br, nbr, m2r, ao};
    endfunction

    function automatic logic [1:0] exp_psrc(input kind_t k, input logic z);
        case (k)
            K_J, K_JAL: return 2'b10;
            K_JR:       return 2'b11;
            K_BEQ:      return z ? 2'b01 : 2'b00;
            K_BNE:      return z ? 2'b00 : 2'b01;
            default:    return 2'b00;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", 32'({hs_obs, dec_obs, state, bus_err, halted}), 32'd0);
        chk("rst_retired", retired, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_retired = 0;
    endtask

    // Expected per-cycle state list comes from the instruction's phase sequence and wait counts.
    task automatic run_instr(input logic [31:0] w, input logic z, input int fw, input int mw);
        kind_t k;
        int    sq[$];
        bit    rq[$];
        int    s;
        bit    last;
        logic [1:0] ps;
        k = classify(w);
        for (int i = 0; i <= fw; i++) begin sq.push_back(0); rq.push_back(i == fw); end
        sq.push_back(1); rq.push_back(1'($urandom_range(0, 1)));
        if (k == K_ILL) begin
            sq.push_back(7); rq.push_back(1'b1);
            sq.push_back(7); rq.push_back(1'b0);
        end else begin
            sq.push_back(2); rq.push_back(1'($urandom_range(0, 1)));
            if (k == K_LW || k == K_SW)
                for (int i = 0; i <= mw; i++) begin sq.push_back(3); rq.push_back(i == mw); end
            if (k == K_R || k == K_I || k == K_LW || k == K_JAL) begin
                sq.push_back(4); rq.push_back(1'($urandom_range(0, 1)));
            end
        end
        ps = exp_psrc(k, z);
        for (int i = 0; i < sq.size(); i++) begin
            inst = w;
            zero = z;
            mem_ready = rq[i];
            @(negedge clk);
            s = sq[i];
            last = (k != K_ILL) && (i == sq.size() - 1);
            chk("state", 32'(state), 32'(s));
            chk("handshake", 32'(hs_obs),
                32'({s == 0 || s == 3, s == 3 && k == K_SW, s == 0 && rq[i], last, s == 4,
                     last ? ps : 2'b00}));
            chk("decoded", 32'(dec_obs), (s >= 2 && s <= 4) ? 32'(exp_dec(k, w)) : 32'd0);
            chk("halted", 32'(halted), 32'(s == 7));
            chk("bus_err", 32'(bus_err), 32'd0);
            chk("retired", retired, model_retired);
            @(posedge clk);
            #1;
        end
        if (k != K_ILL) model_retired++;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] w;
        do_reset();

        run_instr(32'h00221820, 1'b0, 0, 0);  // add $3,$1,$2
        run_instr(32'h8C220004, 1'b0, 0, 2);  // lw with two MEM waits
        run_instr(32'hAC220004, 1'b1, 1, 1);  // sw
        run_instr(32'h10220003, 1'b1, 0, 0);  // beq taken
        run_instr(32'h10220003, 1'b0, 0, 0);  // beq not taken
        run_instr(32'h14220003, 1'b1, 0, 0);  // bne not taken
        run_instr(32'h14220003, 1'b0, 0, 0);  // bne taken
        run_instr(32'h00021080, 1'b0, 4, 0);  // sll, handshake on the watchdog limit cycle
        run_instr(32'h8C220004, 1'b0, 2, 4);  // lw, handshake on the watchdog limit cycle

        do_reset();
        run_instr(32'h0C000010, 1'b0, 0, 0);  // jal
        run_instr(32'h03E00008, 1'b0, 0, 0);  // jr $31
        mem_ready = 1'b0;
        @(negedge clk);
        chk("retired_pair", retired, 32'd2);

        do_reset();
        for (int n = 0; n < 40; n++) begin
            r = $urandom;
            case ($urandom_range(0, 8))
                0: w = {6'h00, r[25:0]};
                1: w = {6'h00, r[25:21], 15'd0, 6'h08};
                2: w = {3'b001, r[28:0]};
                3: w = {6'h23, r[25:0]};
                4: w = {6'h2B, r[25:0]};
                5: w = {6'h04, r[25:0]};
                6: w = {6'h05, r[25:0]};
                7: w = {6'h02, r[25:0]};
                default: w = {6'h03, r[25:0]};
            endcase
            run_instr(w, 1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 4));
        end

        // Reset while a store is waiting in MEM must suppress the write immediately.
        inst = 32'hAC220004;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("sw_in_mem", 32'({state, mem_we}), 32'({3'd3, 1'b1}));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ctl", 32'({hs_obs, dec_obs, state, bus_err, halted}), 32'd0);
        chk("abort_retired", retired, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_retired = 0;
        @(negedge clk);
        chk("abort_after", 32'({state, mem_req, mem_we}), 32'({3'd0, 1'b1, 1'b0}));
        chk("abort_after_retired", retired, 32'd0);

        do_reset();
        run_instr(32'h00221820, 1'b0, 0, 0);
        run_instr(32'hFC000000, 1'b0, 0, 0);  // illegal op halts, retired stays 1

        do_reset();
        inst = 32'h00221820;
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("wd_wait", 32'({state, mem_req, ir_write, bus_err}), 32'({3'd0, 1'b1, 1'b0, 1'b0}));
            @(posedge clk); #1;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("wd_halt", 32'({state, bus_err, halted, mem_req, pc_write, ir_write}),
                32'({3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
            @(posedge clk); #1;
        end
        do_reset();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("wd_cleared", 32'({state, bus_err, halted}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
